gfx256_rect_raster: RTL and testbench

GFX256_RECT_RASTER -- requirements
Module: gfx256_rect_raster

---
 rtl/gfx256_rect_raster.sv | 171 +++++++++++++++++
 tb/tb_gfx256_rect_raster.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx256_rect_raster.sv
// Rectangle rasterizer: walks an inclusive, optionally clipped rectangle row-major and hands
// one pixel at a time to the renderer. Define GFX256_RECT_CLIP_EN to apply the clip window.
module gfx256_rect_raster #(
    parameter int unsigned point_width = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [point_width-1:0]     x0_i,
    input  logic [point_width-1:0]     y0_i,
    input  logic [point_width-1:0]     x1_i,
    input  logic [point_width-1:0]     y1_i,
    input  logic [point_width-1:0]     clip_x0_i,
    input  logic [point_width-1:0]     clip_y0_i,
    input  logic [point_width-1:0]     clip_x1_i,
    input  logic [point_width-1:0]     clip_y1_i,
    input  logic [point_width-1:0]     z_i,
    input  logic [31:0]                color_i,
    input  logic                       abort_i,
    output logic [point_width-1:0]     pixel_x_o,
    output logic [point_width-1:0]     pixel_y_o,
    output logic [point_width-1:0]     pixel_z_o,
    output logic [31:0]                color_o,
    output logic                       write_o,
    input  logic                       ack_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [2*point_width-1:0]   count_o
);

    typedef enum logic [2:0] {StIdle, StSetup, StEmit, StWaitAck, StDone} state_e;

    localparam logic [point_width-1:0]   PointOne = 1;
    localparam logic [2*point_width-1:0] CountOne = 1;

    state_e                 state_q;
    logic [point_width-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [point_width-1:0] xs_q, xe_q, ye_q;
    logic [point_width-1:0] xs_c, xe_c, ys_c, ye_c;
    logic                   abort_q;
    logic                   abort_now;
    logic                   last_pixel;

`ifdef GFX256_RECT_CLIP_EN
    logic [point_width-1:0] cx0_q, cy0_q, cx1_q, cy1_q;

    always_comb begin
        xs_c = (x0_q > cx0_q) ? x0_q : cx0_q;
        ys_c = (y0_q > cy0_q) ? y0_q : cy0_q;
        xe_c = (x1_q < cx1_q) ? x1_q : cx1_q;
        ye_c = (y1_q < cy1_q) ? y1_q : cy1_q;
    end
`else
    logic unused_clip;
    assign unused_clip = ^{clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i};

    always_comb begin
        xs_c = x0_q;
        ys_c = y0_q;
        xe_c = x1_q;
        ye_c = y1_q;
    end
`endif

    // An abort arriving in the same cycle as the decision counts immediately.
    assign abort_now  = abort_q | abort_i;
    assign last_pixel = (pixel_x_o == xe_q) && (pixel_y_o == ye_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            xs_q      <= '0;
            xe_q      <= '0;
            ye_q      <= '0;
`ifdef GFX256_RECT_CLIP_EN
            cx0_q     <= '0;
            cy0_q     <= '0;
            cx1_q     <= '0;
            cy1_q     <= '0;
`endif
            abort_q   <= 1'b0;
            pixel_x_o <= '0;
            pixel_y_o <= '0;
            pixel_z_o <= '0;
            color_o   <= '0;
            write_o   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            count_o   <= '0;
        end else begin
            write_o <= 1'b0;
            done_o  <= 1'b0;
            if (state_q != StIdle && abort_i) begin
                abort_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        x0_q      <= x0_i;
                        y0_q      <= y0_i;
                        x1_q      <= x1_i;
                        y1_q      <= y1_i;
`ifdef GFX256_RECT_CLIP_EN
                        cx0_q     <= clip_x0_i;
                        cy0_q     <= clip_y0_i;
                        cx1_q     <= clip_x1_i;
                        cy1_q     <= clip_y1_i;
`endif
                        pixel_z_o <= z_i;
                        color_o   <= color_i;
                        count_o   <= '0;
                        busy_o    <= 1'b1;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    xs_q      <= xs_c;
                    xe_q      <= xe_c;
                    ye_q      <= ye_c;
                    pixel_x_o <= xs_c;
                    pixel_y_o <= ys_c;
                    if (xs_c > xe_c || ys_c > ye_c) begin
                        done_o  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        write_o <= ~abort_now;
                        state_q <= StEmit;
                    end
                end
                StEmit: begin
                    // Flag here means the abort landed during setup and no write went out.
                    if (abort_q) begin
                        done_o  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        state_q <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (ack_i) begin
                        count_o <= count_o + CountOne;
                        if (abort_now || last_pixel) begin
                            done_o  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            if (pixel_x_o == xe_q) begin
                                pixel_x_o <= xs_q;
                                pixel_y_o <= pixel_y_o + PointOne;
                            end else begin
                                pixel_x_o <= pixel_x_o + PointOne;
                            end
                            write_o <= 1'b1;
                            state_q <= StEmit;
                        end
                    end
                end
                StDone: begin
                    abort_q <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gfx256_rect_raster.sv
// Scoreboard bench for gfx256_rect_raster: a plain-arithmetic rectangle model queues expected
// pixels and done counts; an independent monitor compares whatever the DUT emits.
module tb_gfx256_rect_raster;

    localparam int unsigned PW = 16;

    logic          clk = 1'b0;
    logic          rst, start, abort, ack;
    logic [PW-1:0] x0, y0, x1, y1, cx0, cy0, cx1, cy1, z;
    logic [31:0]   color;
    logic [PW-1:0] px, py, pz;
    logic [31:0]   color_out;
    logic          write, busy, done;
    logic [2*PW-1:0] count;

    always #5 clk = ~clk;

    gfx256_rect_raster #(.point_width(PW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .x0_i(x0), .y0_i(y0), .x1_i(x1), .y1_i(y1),
        .clip_x0_i(cx0), .clip_y0_i(cy0), .clip_x1_i(cx1), .clip_y1_i(cy1),
        .z_i(z), .color_i(color), .abort_i(abort),
        .pixel_x_o(px), .pixel_y_o(py), .pixel_z_o(pz), .color_o(color_out),
        .write_o(write), .ack_i(ack), .busy_o(busy), .done_o(done), .count_o(count)
    );

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [31:0] c;
    } pix_t;

    pix_t        exp_pix[$];
    int unsigned exp_done[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int write_cnt = 0;
    int done_cnt = 0;
    int last_write_cyc = 0;
    int last_done_cyc = 0;
    int ack_delay = 0;
    bit ack_rand = 1'b1;
    logic [15:0] held_x, held_y;
    bit prev_ack_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp16(input int v);
        return (v < 0) ? 0 : ((v > 65535) ? 65535 : v);
    endfunction

    // Monitor: every DUT-presented write or done is matched against the scoreboard.
    always @(negedge clk) begin
        pix_t p;
        if (prev_ack_busy) check("write_or_done_after_ack", {63'd0, write | done}, 64'd1);
        prev_ack_busy = ack && busy && !rst;
        if (ack && busy && !rst) check("pixel_stable_until_ack", {32'd0, px, py},
                                       {32'd0, held_x, held_y});
        if (write) begin
            write_cnt++;
            last_write_cyc = cyc;
            held_x = px;
            held_y = py;
            if (exp_pix.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got pixel (%0h,%0h), expected none", px, py);
            end else begin
                p = exp_pix.pop_front();
                check("pixel_x", {48'd0, px}, {48'd0, p.x});
                check("pixel_y", {48'd0, py}, {48'd0, p.y});
                check("pixel_z_color", {16'd0, pz, color_out}, {16'd0, p.z, p.c});
            end
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (exp_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 with count %0d, expected none", count);
            end else begin
                check("done_count", {32'd0, count}, {32'd0, exp_done.pop_front()});
            end
        end
    end

    // Renderer model: acknowledges each write after a fixed or random delay.
    initial begin
        int d;
        ack = 1'b0;
        forever begin
            @(negedge clk);
            if (write) begin
                d = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
                repeat (d) @(posedge clk);
                @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
            end
        end
    end

    task automatic model(input int ax0, ay0, ax1, ay1, acx0, acy0, acx1, acy1,
                         input logic [15:0] az, input logic [31:0] ac, input int max_pix);
        int xs, xe, ys, ye, n;
        pix_t p;
`ifdef GFX256_RECT_CLIP_EN
        xs = (ax0 > acx0) ? ax0 : acx0;
        ys = (ay0 > acy0) ? ay0 : acy0;
        xe = (ax1 < acx1) ? ax1 : acx1;
        ye = (ay1 < acy1) ? ay1 : acy1;
`else
        xs = ax0; ys = ay0; xe = ax1; ye = ay1;
`endif
        n = 0;
        for (int yy = ys; yy <= ye; yy++) begin
            for (int xx = xs; xx <= xe; xx++) begin
                if (max_pix < 0 || n < max_pix) begin
                    p.x = 16'(xx);
                    p.y = 16'(yy);
                    p.z = az;
                    p.c = ac;
                    exp_pix.push_back(p);
                    n++;
                end
            end
        end
        exp_done.push_back(n);
    endtask

    task automatic run_rect(input int ax0, ay0, ax1, ay1, acx0, acy0, acx1, acy1,
                            input int max_pix, input int abort_at, output int st_cyc);
        logic [15:0] az;
        logic [31:0] ac;
        int n, d0, w0;
        bit aborted;
        az = 16'($urandom);
        ac = $urandom;
        model(ax0, ay0, ax1, ay1, acx0, acy0, acx1, acy1, az, ac, max_pix);
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        x0 = 16'(ax0); y0 = 16'(ay0); x1 = 16'(ax1); y1 = 16'(ay1);
        cx0 = 16'(acx0); cy0 = 16'(acy0); cx1 = 16'(acx1); cy1 = 16'(acy1);
        z = az; color = ac; start = 1'b1;
        st_cyc = cyc;
        d0 = done_cnt;
        w0 = write_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble inputs to show the DUT works from its latched copies.
        x0 = 16'($urandom); y0 = 16'($urandom); x1 = 16'($urandom); y1 = 16'($urandom);
        cx0 = 16'($urandom); cy0 = 16'($urandom); cx1 = 16'($urandom); cy1 = 16'($urandom);
        z = 16'($urandom); color = $urandom;
        n = 0;
        aborted = 1'b0;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge clk);
            #1;
            abort = 1'b0;
            if (!aborted && abort_at > 0 && write_cnt == w0 + abort_at) begin
                abort = 1'b1;
                aborted = 1'b1;
            end
            n++;
        end
        abort = 1'b0;
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done_o in %0d cycles, expected one", n);
            exp_pix.delete();
            exp_done.delete();
        end
    endtask

    initial begin
        int sc, w0, d0, n;
        int rx0, ry0, rx1, ry1, base;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        cx0 = '0; cy0 = '0; cx1 = '0; cy1 = '0;
        z = '0; color = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_write_done_busy", {61'd0, write, done, busy}, 64'd0);
        check("reset_count", {32'd0, count}, 64'd0);
        check("reset_pixel", {16'd0, px, py, pz}, 64'd0);
        check("reset_color", {32'd0, color_out}, 64'd0);
        rst = 1'b0;

        // Directed: 2x2 with fixed 3-cycle ack latency, then count holds in idle.
        ack_rand = 1'b0;
        ack_delay = 2;
        run_rect(10, 20, 11, 21, 0, 0, 65535, 65535, -1, 0, sc);
        repeat (3) @(posedge clk);
        #1 check("count_holds_in_idle", {32'd0, count}, 64'd4);

        // Single pixel: write two cycles after start.
        ack_delay = 0;
        run_rect(5, 5, 5, 5, 0, 0, 65535, 65535, -1, 0, sc);
        check("single_write_latency", 64'(last_write_cyc - sc), 64'd2);

        // Inverted rectangle: done two cycles after start, no write.
        w0 = write_cnt;
        run_rect(9, 0, 3, 0, 0, 0, 65535, 65535, -1, 0, sc);
        check("empty_done_latency", 64'(last_done_cyc - sc), 64'd2);
        check("empty_no_write", 64'(write_cnt - w0), 64'd0);

        // Clip window (pixel count depends on the build), and the top coordinate edge.
        ack_rand = 1'b1;
        run_rect(0, 0, 9, 9, 5, 5, 100, 100, -1, 0, sc);
        run_rect(65534, 65535, 65535, 65535, 0, 0, 65535, 65535, -1, 0, sc);

        // Abort during the third WAIT_ACK of a 4x4.
        ack_rand = 1'b0;
        ack_delay = 3;
        run_rect(100, 200, 103, 203, 0, 0, 65535, 65535, 3, 3, sc);

        // Reset mid-rectangle: busy drops next cycle, no done, late ack ignored.
        exp_pix.push_back({16'd40, 16'd50, 16'h1234, 32'hCAFEF00D});
        exp_pix.push_back({16'd41, 16'd50, 16'h1234, 32'hCAFEF00D});
        @(posedge clk);
        #1;
        x0 = 16'd40; y0 = 16'd50; x1 = 16'd43; y1 = 16'd53;
        cx0 = '0; cy0 = '0; cx1 = 16'hFFFF; cy1 = 16'hFFFF;
        z = 16'h1234; color = 32'hCAFEF00D; start = 1'b1;
        w0 = write_cnt;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (write_cnt < w0 + 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1 rst = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1 rst = 1'b0;
        check("busy_after_reset", {63'd0, busy}, 64'd0);
        repeat (20) @(posedge clk);
        #1;
        check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        check("count_after_reset", {32'd0, count}, 64'd0);
        check("writes_before_reset", 64'(write_cnt - w0), 64'd2);

        // Random small rectangles, some empty, some pinned against 0xFFFF.
        ack_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            base = ($urandom_range(0, 5) == 0) ? 65532 : int'($urandom_range(0, 65000));
            rx0 = clamp16(base + int'($urandom_range(0, 3)));
            ry0 = clamp16(base + int'($urandom_range(0, 3)));
            rx1 = clamp16(rx0 + int'($urandom_range(0, 3)) - (($urandom_range(0, 5) == 0) ? 4 : 0));
            ry1 = clamp16(ry0 + int'($urandom_range(0, 3)) - (($urandom_range(0, 5) == 0) ? 4 : 0));
            run_rect(rx0, ry0, rx1, ry1,
                     clamp16(rx0 + int'($urandom_range(0, 2)) - 1),
                     clamp16(ry0 + int'($urandom_range(0, 2)) - 1),
                     clamp16(rx1 + int'($urandom_range(0, 2)) - 1),
                     clamp16(ry1 + int'($urandom_range(0, 2)) - 1), -1, 0, sc);
        end

        repeat (10) @(posedge clk);
        check("leftover_pixels", 64'(exp_pix.size()), 64'd0);
        check("leftover_dones", 64'(exp_done.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
